dmem_cache_ctrl: RTL and testbench
==================================

Name: dmem_cache_ctrl

Overview:
- Data-memory-side responder that produces the `dmemError` stall request consumed by the pipeline register controller.
- Direct-mapped, write-through, write-allocate cache with one word per line, placed between the MEM stage and a multi-cycle main memory.
- Drives main memory through a req/ack handshake.
- Holds `dmemError` high until the MEM-stage access has retired, so the whole pipeline freezes for the duration of a miss or write-through.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- INDEX_W, 4, line index bits (2**INDEX_W lines)

Ports:
- Clk  input  1  system clock, rising-edge active
- Rst  input  1  asynchronous active-low reset
- MEM_memRead  input  1  MEM-stage load request
- MEM_memWrite  input  1  MEM-stage store request
- MEM_addr  input  ADDR_W  byte address; index = [INDEX_W+1:2], tag = [ADDR_W-1:INDEX_W+2]
- MEM_wdata  input  DATA_W  store data
- rdata  output  DATA_W  load data to MEM stage
- dmemError  output  1  access not complete this cycle; stall all stages
- mem_req  output  1  main-memory request, held until ack
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  word-aligned main-memory address (bits [1:0] = 0)
- mem_wdata  output  DATA_W  main-memory write data
- mem_rdata  input  DATA_W  main-memory read data, valid with mem_ack
- mem_ack  input  1  single-cycle completion pulse from main memory

Behaviour:
- Reset (Rst = 0, asynchronous):
  - state = IDLE; all valid bits = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Latched address, latched data and refill register = 0.
- Access definition: acc = MEM_memRead | MEM_memWrite. If both are high, treat the access as a write.
- States: IDLE, RD_MISS, WR_THRU, RESUME.
- IDLE:
  - acc = 0: dmemError = 0; rdata = 0.
  - Read hit (valid && tag match): rdata = line data combinationally; dmemError = 0; stay in IDLE. Zero-cycle latency.
  - Read miss: dmemError = 1 combinationally in the same cycle. At the clock edge, latch address, set mem_req = 1 and mem_we = 0, go to RD_MISS.
  - Write (hit or miss): dmemError = 1 combinationally. At the clock edge, latch address and data, set mem_req = 1 and mem_we = 1, go to WR_THRU.
- RD_MISS:
  - dmemError = 1; mem_req held until mem_ack.
  - On mem_ack: write line (valid = 1, tag, mem_rdata); capture mem_rdata into the refill register; drop mem_req; go to RESUME.
- WR_THRU:
  - dmemError = 1; mem_req held until mem_ack.
  - On mem_ack: allocate/update line (valid = 1, tag, latched data); drop mem_req; go to RESUME.
- RESUME (one cycle):
  - dmemError = 0, so the pipeline advances and retires the access.
  - For a read, rdata = refill register.
  - The access currently presented is NOT re-evaluated; go to IDLE unconditionally.
- dmemError is combinational from state and inputs. It is stable before the falling edge, because the pipeline controller samples it on negedge Clk.
- mem_addr and mem_wdata come from the latched registers. Changes on MEM_addr or MEM_wdata during RD_MISS or WR_THRU are ignored.
- mem_ack outside RD_MISS or WR_THRU is ignored.
- mem_ack in the same cycle mem_req first rises: not possible, since req rises at the edge. An ack in the first cycle req is high is accepted.
- Reset asserted mid-miss: abort immediately. mem_req = 0, cache invalidated, no partial line written.
- Back-to-back accesses: after RESUME, the next access is evaluated in IDLE on the following cycle. Minimum miss penalty = 2 stall cycles + memory latency.

Test Plan:
- Reset then read 0x0000_0040 (index 0, cold miss), mem_ack 3 cycles after req with mem_rdata = 0xDEAD_BEEF:
  - dmemError high from the request cycle through the ack cycle.
  - RESUME cycle: rdata = 0xDEAD_BEEF, dmemError = 0.
- Reread 0x0000_0040 → hit: rdata = 0xDEAD_BEEF in the same cycle, dmemError = 0, mem_req never asserted.
- Write 0x1234_5678 to 0x0000_0040 → mem_req = 1, mem_we = 1, mem_addr = 0x40, mem_wdata = 0x1234_5678 held until ack; one RESUME cycle. A following read hits with 0x1234_5678.
- Conflict: read 0x0000_0080 with INDEX_W = 4 (same index, different tag as 0x40) → miss; refill replaces the line; a subsequent read of 0x40 misses again.
- MEM_addr changed to 0x100 while in RD_MISS → mem_addr stays 0x40; the line is filled for 0x40 only.
- Rst pulled low while in WR_THRU before ack → mem_req = 0 and dmemError = 0 immediately. After release, a read of 0x40 misses (valid bits cleared).

Source files
------------

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate data cache (one word per line)
// between the MEM stage and a req/ack main memory; stalls the pipeline via dmemError.
module dmem_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MEM_memRead,
  input  logic              MEM_memWrite,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              dmemError,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESUME} state_t;

  state_t              state;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tags  [LINES];
  logic [DATA_W-1:0]   lines [LINES];
  logic [DATA_W-1:0]   refill;

  logic                acc;
  logic                hit;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag_in;
  logic [INDEX_W-1:0]  lidx;
  logic [TAG_W-1:0]    ltag;
  logic                line_wr;
  logic                addr_lsb_unused;

  assign acc     = MEM_memRead | MEM_memWrite;
  assign idx     = MEM_addr[INDEX_W+1:2];
  assign tag_in  = MEM_addr[ADDR_W-1:INDEX_W+2];
  assign hit     = valid[idx] && (tags[idx] == tag_in);
  // the latched request address doubles as the line address for the refill/allocate
  assign lidx    = mem_addr[INDEX_W+1:2];
  assign ltag    = mem_addr[ADDR_W-1:INDEX_W+2];
  assign line_wr = mem_ack && ((state == RD_MISS) || (state == WR_THRU));
  assign addr_lsb_unused = ^MEM_addr[1:0];

  // dmemError is forced low while reset is held so an aborted miss releases the pipeline
  always_comb begin
    dmemError = 1'b0;
    rdata     = '0;
    if (Rst) begin
      case (state)
        IDLE: begin
          if (acc) begin
            if (!MEM_memWrite && hit) rdata = lines[idx];
            else                      dmemError = 1'b1;
          end
        end
        RD_MISS, WR_THRU: dmemError = 1'b1;
        RESUME: begin
          if (!mem_we) rdata = refill;
        end
        default: dmemError = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      refill    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && (MEM_memWrite || !hit)) begin
            mem_addr <= {MEM_addr[ADDR_W-1:2], 2'b00};
            mem_req  <= 1'b1;
            mem_we   <= MEM_memWrite;
            if (MEM_memWrite) begin
              mem_wdata <= MEM_wdata;
              state     <= WR_THRU;
            end else begin
              state     <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            valid[lidx] <= 1'b1;
            refill      <= mem_rdata;
            mem_req     <= 1'b0;
            state       <= RESUME;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            valid[lidx] <= 1'b1;
            mem_req     <= 1'b0;
            state       <= RESUME;
          end
        end
        RESUME:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // tag/data storage needs no reset: valid bits gate every use
  always_ff @(posedge Clk) begin
    if (line_wr) begin
      tags[lidx]  <= ltag;
      lines[lidx] <= (state == RD_MISS) ? mem_rdata : mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Self-checking bench for dmem_cache_ctrl: transaction-level cache/memory model,
// per-cycle compare on negedge, directed scenarios followed by random traffic.
module tb_dmem_cache_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MEM_memRead, MEM_memWrite;
  logic [31:0] MEM_addr, MEM_wdata;
  logic [31:0] rdata;
  logic        dmemError;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  dmem_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .MEM_memRead(MEM_memRead), .MEM_memWrite(MEM_memWrite),
    .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
    .rdata(rdata), .dmemError(dmemError),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // expectations for the current cycle, set by the driver just after posedge
  logic        chk_en = 1'b0;
  logic        exp_err, exp_req, exp_we, chk_rdata;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;

  // behavioural model: cache lines plus backing memory
  bit          mvalid [16];
  logic [25:0] mtag   [16];
  logic [31:0] mdata  [16];
  logic [31:0] mainmem [logic [31:0]];
  logic [31:0] last_rd;
  bit          last_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("dmemError", {31'b0, dmemError}, {31'b0, exp_err});
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (chk_rdata) check("rdata", rdata, exp_rdata);
      if (exp_req) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_cycle(input bit spur_ack);
    MEM_memRead = 1'b0; MEM_memWrite = 1'b0;
    MEM_addr = $urandom; MEM_wdata = $urandom;
    mem_ack = spur_ack; mem_rdata = $urandom;
    chk_en = 1'b1; exp_err = 1'b0; exp_req = 1'b0; chk_rdata = 1'b1; exp_rdata = '0;
    tick();
    mem_ack = 1'b0;
  endtask

  // scramble: 0 = hold inputs, 1 = random MEM_addr/wdata, 2 = MEM_addr = 0x100 while waiting
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat, input int scramble);
    logic [31:0] waddr;
    int          idx;
    logic [25:0] tag;
    bit          hit;
    logic [31:0] v;
    waddr = {addr[31:2], 2'b00};
    idx   = int'(addr[5:2]);
    tag   = addr[31:6];
    hit   = !wr && mvalid[idx] && (mtag[idx] == tag);
    MEM_memRead = rd; MEM_memWrite = wr; MEM_addr = addr; MEM_wdata = wd; mem_ack = 1'b0;
    chk_en = 1'b1; exp_req = 1'b0; exp_err = !hit; chk_rdata = hit; exp_rdata = mdata[idx];
    last_miss = !hit;
    tick();
    if (hit) begin
      last_rd = mdata[idx];
      return;
    end
    if (wr) v = wd;
    else if (mainmem.exists(waddr)) v = mainmem[waddr];
    else v = $urandom;
    for (int c = 1; c <= lat; c++) begin
      exp_err = 1'b1; exp_req = 1'b1; exp_we = wr; exp_addr = waddr; exp_wdata = wd;
      chk_rdata = 1'b0;
      if (scramble == 1) begin MEM_addr = $urandom; MEM_wdata = $urandom; end
      if (scramble == 2) MEM_addr = 32'h100;
      if (c == lat) begin
        mem_ack = 1'b1;
        mem_rdata = wr ? $urandom : v;
      end else begin
        mem_rdata = $urandom;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = $urandom; MEM_addr = addr; MEM_wdata = wd;
    exp_err = 1'b0; exp_req = 1'b0; chk_rdata = !wr; exp_rdata = v;
    mvalid[idx] = 1'b1; mtag[idx] = tag; mdata[idx] = v; mainmem[waddr] = v;
    last_rd = v;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; MEM_memRead = 1'b0; MEM_memWrite = 1'b0;
    MEM_addr = '0; MEM_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_dmemError", {31'b0, dmemError}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    // cold miss, then hit, write-through, hit on written data
    mainmem[32'h40] = 32'hDEADBEEF;
    mainmem[32'h80] = 32'hCAFEF00D;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 0);
    check("model_cold_miss", {31'b0, last_miss}, 32'd1);
    check("model_refill", last_rd, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 0);
    check("model_reread_hit", {31'b0, last_miss}, 32'd0);
    check("model_reread", last_rd, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'h40, 32'h12345678, 2, 0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 0);
    check("model_after_write", last_rd, 32'h12345678);

    // conflict eviction at index 0
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 1, 0);
    check("model_conflict", last_rd, 32'hCAFEF00D);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 4, 2);
    check("model_evicted_miss", {31'b0, last_miss}, 32'd1);
    check("model_refetch", last_rd, 32'h12345678);
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 0);
    check("model_0x100_miss", {31'b0, last_miss}, 32'd1);
    idle_cycle(1'b1);

    // reset during write-through before ack
    chk_en = 1'b0;
    MEM_memRead = 1'b0; MEM_memWrite = 1'b1; MEM_addr = 32'h40; MEM_wdata = 32'hA5A5A5A5;
    tick();
    tick();
    check("wthru_req", {31'b0, mem_req}, 32'd1);
    check("wthru_err", {31'b0, dmemError}, 32'd1);
    Rst = 1'b0;
    #1;
    check("abort_req", {31'b0, mem_req}, 32'd0);
    check("abort_err", {31'b0, dmemError}, 32'd0);
    tick();
    Rst = 1'b1;
    MEM_memWrite = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 2, 0);
    check("model_post_reset_miss", {31'b0, last_miss}, 32'd1);

    // random traffic over a small address space so hits and conflicts are frequent
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      logic [31:0] a;
      a  = {24'b0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      op = $urandom_range(0, 9);
      if (op < 2)       idle_cycle(1'($urandom));
      else if (op < 6)  do_access(1'b1, 1'b0, a, 32'h0, $urandom_range(1, 4), $urandom_range(0, 1));
      else if (op < 9)  do_access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 4), $urandom_range(0, 1));
      else              do_access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4), $urandom_range(0, 1));
    end
    idle_cycle(1'b0);
    chk_en = 1'b0;
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
